// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage. It extracts load data, selects the
// writeback source, drives the register-file write port and counts retired instructions.
module mem_wb_stage #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic [ADDR_W-1:0] in_wa,
  input  logic [1:0]        in_wb_sel,
  input  logic [2:0]        in_mem_op,
  input  logic [1:0]        in_byte_off,
  input  logic [31:0]       in_alu_result,
  input  logic [31:0]       in_mem_rdata,
  input  logic [31:0]       in_pc_plus8,
  output logic              WE,
  output logic [ADDR_W-1:0] WA,
  output logic [31:0]       WD,
  output logic              valid_o,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LB  = 3'b001,
    OP_LBU = 3'b010,
    OP_LH  = 3'b011,
    OP_LHU = 3'b100
  } mem_op_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_ALU2 = 2'b11
  } wb_sel_e;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic              valid_q, valid_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [7:0]  lane;
  logic [15:0] half;
  logic [31:0] load_data;
  logic [31:0] wb_data;
  logic        misaligned;

  // Load extraction and writeback source select.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    lane       = in_mem_rdata[7:0];
    half       = in_byte_off[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    load_data  = in_mem_rdata;
    misaligned = 1'b0;
    wb_data    = in_alu_result;

    case (in_byte_off)
      2'd0:    lane = in_mem_rdata[7:0];
      2'd1:    lane = in_mem_rdata[15:8];
      2'd2:    lane = in_mem_rdata[23:16];
      default: lane = in_mem_rdata[31:24];
    endcase

    case (in_mem_op)
      OP_LB:   load_data = {{24{lane[7]}}, lane};
      OP_LBU:  load_data = {24'b0, lane};
      OP_LH:   load_data = {{16{half[15]}}, half};
      OP_LHU:  load_data = {16'b0, half};
      default: load_data = in_mem_rdata;
    endcase

    if (in_valid && (in_wb_sel == WB_MEM)) begin
      case (in_mem_op)
        OP_LB, OP_LBU: misaligned = 1'b0;
        OP_LH, OP_LHU: misaligned = in_byte_off[0];
        default:       misaligned = (in_byte_off != 2'd0);
      endcase
    end

    case (in_wb_sel)
      WB_MEM:  wb_data = misaligned ? 32'd0 : load_data;
      WB_LINK: wb_data = in_pc_plus8;
      default: wb_data = in_alu_result;
    endcase
  end

  // Next-state: flush beats stall beats capture; reset is applied in the register.
  always_comb begin
    we_d       = we_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    valid_d    = valid_q;
    misalign_d = 1'b0;
    cnt_d      = cnt_q;

    if (flush) begin
      we_d    = 1'b0;
      wa_d    = '0;
      wd_d    = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d    = in_valid;
      wa_d       = in_wa;
      wd_d       = wb_data;
      misalign_d = misaligned;
      // Never write $0, so it reads as zero regardless of the register file.
      we_d       = in_valid && in_reg_write && (in_wa != '0) && !misaligned;
      if (in_valid) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign WE           = we_q;
  assign WA           = wa_q;
  assign WD           = wd_q;
  assign valid_o      = valid_q;
  assign misalign_err = misalign_q;
  assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, hand-written stall/flush/reset
// sequences and random stimulus against a behavioural model. A 4-bit counter build covers wrap.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, in_reg_write;
  logic [4:0]  in_wa;
  logic [1:0]  in_wb_sel, in_byte_off;
  logic [2:0]  in_mem_op;
  logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus8;

  logic        we, valid_o, mis;
  logic [4:0]  wa;
  logic [31:0] wd, cnt;
  logic        we4, valid4, mis4;
  logic [4:0]  wa4;
  logic [31:0] wd4;
  logic [3:0]  cnt4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_wa(in_wa), .in_wb_sel(in_wb_sel),
    .in_mem_op(in_mem_op), .in_byte_off(in_byte_off), .in_alu_result(in_alu_result),
    .in_mem_rdata(in_mem_rdata), .in_pc_plus8(in_pc_plus8),
    .WE(we), .WA(wa), .WD(wd), .valid_o(valid_o), .misalign_err(mis), .retire_cnt(cnt)
  );

  mem_wb_stage #(.ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_wa(in_wa), .in_wb_sel(in_wb_sel),
    .in_mem_op(in_mem_op), .in_byte_off(in_byte_off), .in_alu_result(in_alu_result),
    .in_mem_rdata(in_mem_rdata), .in_pc_plus8(in_pc_plus8),
    .WE(we4), .WA(wa4), .WD(wd4), .valid_o(valid4), .misalign_err(mis4), .retire_cnt(cnt4)
  );

  // Reference model state.
  logic        m_we, m_valid, m_mis, m_dc;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int unsigned m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (op)
      3'd1: return ((sh & 32'hFF) >= 128) ? ((sh & 32'hFF) | 32'hFFFF_FF00) : (sh & 32'hFF);
      3'd2: return sh & 32'hFF;
      3'd3: return ((sh & 32'hFFFF) >= 32768) ? ((sh & 32'hFFFF) | 32'hFFFF_0000) : (sh & 32'hFFFF);
      3'd4: return sh & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic ref_mis(input logic v, input logic [1:0] sel, input logic [2:0] op,
                                   input logic [1:0] off);
    if (!v || sel != 2'd1) return 1'b0;
    if (op == 3'd3 || op == 3'd4) return (off % 2) != 0;
    if (op == 3'd1 || op == 3'd2) return 1'b0;
    return off != 0;
  endfunction

  // Advance one clock, update the model from the sampled inputs, compare after the edge.
  task automatic step();
    logic mi;
    @(posedge clk);
    mi = ref_mis(in_valid, in_wb_sel, in_mem_op, in_byte_off);
    if (rst) begin
      {m_we, m_valid, m_mis, m_dc} = '0;
      m_wa = '0; m_wd = '0; m_cnt = 0;
    end else if (flush) begin
      {m_we, m_valid, m_mis, m_dc} = '0;
      m_wa = '0; m_wd = '0;
    end else if (stall) begin
      m_mis = 1'b0;
    end else begin
      m_mis   = mi;
      m_valid = in_valid;
      m_dc    = !in_valid;
      m_wa    = in_wa;
      if (mi)                  m_wd = 32'd0;
      else if (in_wb_sel == 1) m_wd = ref_load(in_mem_op, in_byte_off, in_mem_rdata);
      else if (in_wb_sel == 2) m_wd = in_pc_plus8;
      else                     m_wd = in_alu_result;
      m_we = in_valid && in_reg_write && (in_wa != 0) && !mi;
      if (in_valid) m_cnt = m_cnt + 1;
    end
    #1;
    check("we", 32'(we), 32'(m_we));
    check("valid_o", 32'(valid_o), 32'(m_valid));
    check("misalign_err", 32'(mis), 32'(m_mis));
    check("retire_cnt", cnt, m_cnt);
    check("retire_cnt4", 32'(cnt4), m_cnt % 16);
    if (!m_dc) begin
      check("wa", 32'(wa), 32'(m_wa));
      check("wd", wd, m_wd);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] a, input logic [1:0] sel,
                       input logic [2:0] op, input logic [1:0] off, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [31:0] pc8);
    in_valid = v; in_reg_write = rw; in_wa = a; in_wb_sel = sel; in_mem_op = op;
    in_byte_off = off; in_alu_result = alu; in_mem_rdata = rd; in_pc_plus8 = pc8;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [1:0]  sel;
    logic [4:0]  wa;
    logic [31:0] alu;
    logic [31:0] pc8;
    logic        exp_we;
    logic [31:0] exp_wd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[10];
  int unsigned cnt_before;

  initial begin
    vecs[0] = '{3'd1, 2'd0, 2'd1, 5'd3,  32'h0, 32'h0, 1'b1, 32'hFFFF_FF81, 1'b0};
    vecs[1] = '{3'd2, 2'd0, 2'd1, 5'd3,  32'h0, 32'h0, 1'b1, 32'h0000_0081, 1'b0};
    vecs[2] = '{3'd1, 2'd1, 2'd1, 5'd3,  32'h0, 32'h0, 1'b1, 32'h0000_007F, 1'b0};
    vecs[3] = '{3'd3, 2'd2, 2'd1, 5'd3,  32'h0, 32'h0, 1'b1, 32'hFFFF_80FF, 1'b0};
    vecs[4] = '{3'd4, 2'd2, 2'd1, 5'd3,  32'h0, 32'h0, 1'b1, 32'h0000_80FF, 1'b0};
    vecs[5] = '{3'd0, 2'd0, 2'd1, 5'd3,  32'h0, 32'h0, 1'b1, 32'h80FF_7F81, 1'b0};
    vecs[6] = '{3'd3, 2'd1, 2'd1, 5'd3,  32'h0, 32'h0, 1'b0, 32'h0000_0000, 1'b1};
    vecs[7] = '{3'd0, 2'd2, 2'd1, 5'd3,  32'h0, 32'h0, 1'b0, 32'h0000_0000, 1'b1};
    vecs[8] = '{3'd0, 2'd0, 2'd0, 5'd0,  32'h55, 32'h0, 1'b0, 32'h0000_0055, 1'b0};
    vecs[9] = '{3'd0, 2'd0, 2'd2, 5'd31, 32'h0, 32'h0040_0008, 1'b1, 32'h0040_0008, 1'b0};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    step(); step();
    check("reset_we", 32'(we), 32'd0);
    check("reset_cnt", cnt, 32'd0);

    // Reset then ALU write.
    rst = 1'b0;
    drive(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'd0, 32'd0);
    step();
    check("alu_we", 32'(we), 32'd1);
    check("alu_wa", 32'(wa), 32'd5);
    check("alu_wd", wd, 32'h1234_5678);
    check("alu_cnt", cnt, 32'd1);

    // Directed load / misalign / $0 / link table.
    for (int i = 0; i < 10; i++) begin
      cnt_before = cnt;
      drive(1'b1, 1'b1, vecs[i].wa, vecs[i].sel, vecs[i].op, vecs[i].off, vecs[i].alu,
            32'h80FF_7F81, vecs[i].pc8);
      step();
      check($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d_wd", i), wd, vecs[i].exp_wd);
      check($sformatf("vec%0d_mis", i), 32'(mis), 32'(vecs[i].exp_mis));
      check($sformatf("vec%0d_cnt", i), cnt, cnt_before + 1);
    end
    drive(1'b1, 1'b1, 5'd4, 2'd0, 3'd0, 2'd0, 32'd9, 32'd0, 32'd0);
    step();
    check("mis_pulse_drop", 32'(mis), 32'd0);

    // Stall holds outputs and freezes the counter, then stall+flush makes a bubble.
    drive(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 2'd0, 32'hA, 32'd0, 32'd0);
    step();
    cnt_before = cnt;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(i + 10), 2'd1, 3'd3, 2'd1, 32'(i + 100), 32'hFFFF_FFFF, 32'd0);
      step();
      check("stall_we", 32'(we), 32'd1);
      check("stall_wa", 32'(wa), 32'd7);
      check("stall_wd", wd, 32'hA);
      check("stall_cnt", cnt, cnt_before);
    end
    flush = 1'b1;
    step();
    check("flush_we", 32'(we), 32'd0);
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_cnt", cnt, cnt_before);
    stall = 1'b0; flush = 1'b0;

    // Reset mid-stall wins.
    drive(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 2'd0, 32'h77, 32'd0, 32'd0);
    step();
    stall = 1'b1; rst = 1'b1;
    step();
    check("rst_stall_we", 32'(we), 32'd0);
    check("rst_stall_cnt", cnt, 32'd0);
    stall = 1'b0; rst = 1'b0;

    // Counter wrap on the 4-bit build, then reset with a capture pending.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 5'(i), 2'd0, 3'd0, 2'd0, 32'(i), 32'd0, 32'd0);
      step();
    end
    check("wrap_cnt4", 32'(cnt4), 32'd0);
    check("wrap_cnt32", cnt, 32'd16);
    rst = 1'b1;
    drive(1'b1, 1'b1, 5'd12, 2'd0, 3'd0, 2'd0, 32'h5, 32'd0, 32'd0);
    step();
    check("rst_pending_cnt4", 32'(cnt4), 32'd0);
    check("rst_pending_we", 32'(we4), 32'd0);
    rst = 1'b0;

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom), 2'($urandom),
            3'($urandom), 2'($urandom), $urandom, $urandom, $urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback stage of the 5-stage MIPS pipeline.
- Sits directly upstream of the register file. Captures the memory-stage result and performs load-data extraction (byte/halfword, sign/zero extend).
- Selects the writeback source and drives the register-file write port (WE, WA, WD). The same registered triple doubles as the WB forwarding source.
- Also keeps a retired-instruction counter and flags misaligned loads.

Parameters:
- ADDR_W, 5, register address width (32 registers).
- CNT_W, 32, retired-instruction counter width.
- Data width is fixed at 32 bits; not parameterised.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hold current stage contents.
- flush  in  1  load a bubble instead of the incoming entry.
- in_valid  in  1  incoming MEM-stage entry is a real instruction.
- in_reg_write  in  1  instruction writes a GPR.
- in_wa  in  ADDR_W  destination register.
- in_wb_sel  in  2  00 ALU, 01 MEM, 10 link (PC+8), 11 ALU.
- in_mem_op  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; 101-111 treated as LW.
- in_byte_off  in  2  address[1:0] of the load.
- in_alu_result  in  32  ALU result / effective address.
- in_mem_rdata  in  32  data memory read word.
- in_pc_plus8  in  32  link value.
- WE  out  1  register-file write enable.
- WA  out  ADDR_W  register-file write address.
- WD  out  32  register-file write data.
- valid_o  out  1  stage holds a real instruction.
- misalign_err  out  1  one-cycle pulse: misaligned load captured.
- retire_cnt  out  CNT_W  count of instructions retired.

Behaviour:
- Latency: one cycle. Inputs are sampled at posedge N; WE/WA/WD/valid_o are valid from N until posedge N+1, when the register file writes.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Priority per posedge: rst > flush > stall > normal capture.
- rst: WE=0, WA=0, WD=0, valid_o=0, misalign_err=0, retire_cnt=0.
- flush: load a bubble. valid_o=0, WE=0, WA=0, WD=0, misalign_err=0. retire_cnt unchanged.
- stall (no flush): all pipeline outputs hold their values, and WE stays as-is (rewriting the same value is idempotent). misalign_err drops to 0. retire_cnt unchanged.
- Normal capture:
  - valid_o <= in_valid.
  - WA <= in_wa.
  - WD <= selected value.
  - WE <= in_valid & in_reg_write & (in_wa != 0) & ~misaligned.
- Writes to $0 are never issued (WE=0), so the $0==0 invariant holds independently of the register file.
- Load extraction (wb_sel=01). Byte lane k = in_mem_rdata[8k+7:8k], k = in_byte_off (little-endian).
  - LB: sign-extend lane k.
  - LBU: zero-extend lane k.
  - LH: sign-extend {lane off+1, lane off}, off ∈ {0,2}.
  - LHU: zero-extend the same halfword.
  - LW: full word; requires off=0.
- Misaligned when wb_sel=01, in_valid=1, and either:
  - LH/LHU with off[0]=1, or
  - LW with off != 0.
- On a misaligned capture: WE=0, WD=0, misalign_err=1 for exactly one cycle, and the instruction is still counted as retired.
- wb_sel 00/11 -> in_alu_result. wb_sel 10 -> in_pc_plus8. in_mem_op and in_byte_off are ignored when wb_sel != 01.
- retire_cnt increments by 1 on each normal capture with in_valid=1. It wraps from 2^CNT_W-1 to 0.
- in_valid=0 on normal capture: valid_o=0, WE=0, misalign_err=0. WA/WD are still loaded but are don't-care.
- Reset mid-stall or mid-flush: reset wins, and all outputs take their reset values the following cycle.

Test Plan:
- Reset then ALU write: rst=1 for 2 cycles, then in_valid=1, reg_write=1, wa=5, wb_sel=00, alu=0x1234_5678 -> next cycle WE=1, WA=5, WD=0x12345678, valid_o=1, retire_cnt=1.
- Loads: rdata=0x80FF_7F81.
  - LB off=0 -> WD=0xFFFFFF81.
  - LBU off=0 -> WD=0x00000081.
  - LB off=1 -> WD=0x0000007F.
  - LH off=2 -> WD=0xFFFF80FF.
  - LHU off=2 -> WD=0x000080FF.
  - LW off=0 -> WD=0x80FF7F81.
- Misaligned: LH off=1 -> WE=0, misalign_err=1 for one cycle, retire_cnt +1. LW off=2 -> same response.
- $0 and link:
  - wa=0, reg_write=1, wb_sel=00 -> WE=0, retire_cnt +1.
  - wa=31, wb_sel=10, pc_plus8=0x0040_0008 -> WE=1, WA=31, WD=0x00400008.
- Stall/flush: capture wa=7, alu=0xA, then stall=1 for 3 cycles while inputs change -> WE=1, WA=7, WD=0xA held and retire_cnt frozen. Then assert stall=1 and flush=1 together -> bubble (WE=0, valid_o=0).
- Counter wrap (CNT_W=4 build): 16 valid captures from reset -> retire_cnt returns to 0. Assert rst with a capture pending -> retire_cnt=0, WE=0.
